// File: rtl/rv64_div_unit_pkg.sv
// Shared types for the RV64M divide unit: op encoding, FSM states and op decode.
package rv64_div_unit_pkg;

  localparam int XLEN        = 64;
  localparam int HALF        = XLEN / 2;
  localparam int DIV_ITER_64 = 64;
  localparam int DIV_ITER_32 = 32;

  typedef enum logic [3:0] {
    M_MUL    = 4'd0,
    M_MULH   = 4'd1,
    M_MULHSU = 4'd2,
    M_MULHU  = 4'd3,
    M_DIV    = 4'd4,
    M_DIVU   = 4'd5,
    M_REM    = 4'd6,
    M_REMU   = 4'd7,
    M_MULW   = 4'd8,
    M_DIVW   = 4'd9,
    M_DIVUW  = 4'd10,
    M_REMW   = 4'd11,
    M_REMUW  = 4'd12
  } mul_op_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_t;

  typedef struct packed {
    logic legal;
    logic is_w;
    logic is_signed;
    logic is_rem;
  } div_dec_t;

  function automatic div_dec_t decode_div_op(logic [3:0] op);
    div_dec_t d;
    d = '0;
    case (op)
      M_DIV:   begin d.legal = 1'b1; d.is_signed = 1'b1; end
      M_DIVU:  begin d.legal = 1'b1; end
      M_REM:   begin d.legal = 1'b1; d.is_signed = 1'b1; d.is_rem = 1'b1; end
      M_REMU:  begin d.legal = 1'b1; d.is_rem = 1'b1; end
      M_DIVW:  begin d.legal = 1'b1; d.is_w = 1'b1; d.is_signed = 1'b1; end
      M_DIVUW: begin d.legal = 1'b1; d.is_w = 1'b1; end
      M_REMW:  begin d.legal = 1'b1; d.is_w = 1'b1; d.is_signed = 1'b1; d.is_rem = 1'b1; end
      M_REMUW: begin d.legal = 1'b1; d.is_w = 1'b1; d.is_rem = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [XLEN-1:0] sext32(logic [HALF-1:0] x);
    return {{HALF{x[HALF-1]}}, x};
  endfunction

endpackage

// File: rtl/rv64_div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/REM (and W forms), one op in flight.
module rv64_div_unit
  import rv64_div_unit_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       op_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  div_state_t      state_reg;
  logic [6:0]      cnt_reg;
  logic [XLEN-1:0] dvd_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] div_reg;
  logic            is_w_reg;
  logic            is_rem_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;

  div_dec_t        dec;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, most_neg, spec_raw, special_result;
  logic            a_neg, b_neg, div_zero, ovf, special;

  assign in_ready_o = rst_n && (state_reg == DIV_IDLE) && !flush_i;
  assign busy_o     = (state_reg != DIV_IDLE);

  // Accept-time decode: operand extension, magnitudes and 1-cycle special cases.
  always_comb begin
    dec   = decode_div_op(op_i);
    a_ext = rs1_i;
    b_ext = rs2_i;
    if (dec.is_w) begin
      a_ext = dec.is_signed ? sext32(rs1_i[HALF-1:0]) : {{HALF{1'b0}}, rs1_i[HALF-1:0]};
      b_ext = dec.is_signed ? sext32(rs2_i[HALF-1:0]) : {{HALF{1'b0}}, rs2_i[HALF-1:0]};
    end
    a_neg    = dec.is_signed & a_ext[XLEN-1];
    b_neg    = dec.is_signed & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    most_neg = dec.is_w ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    ovf      = dec.is_signed && (a_ext == most_neg) && (b_ext == '1);
    special  = !dec.legal || div_zero || ovf;
    spec_raw = '0;
    if (dec.legal) begin
      if (div_zero)
        spec_raw = dec.is_rem ? a_ext : '1;
      else if (ovf)
        spec_raw = dec.is_rem ? '0 : a_ext;
    end
    special_result = dec.is_w ? sext32(spec_raw[HALF-1:0]) : spec_raw;
  end

  logic [XLEN:0]   trial;
  logic            q_bit;
  logic [XLEN-1:0] rem_next, dvd_next, q_fix, r_fix, raw, calc_result;

  // dvd_reg shifts the dividend out of its top while quotient bits enter at the bottom.
  always_comb begin
    trial       = {rem_reg, dvd_reg[XLEN-1]} - {1'b0, div_reg};
    q_bit       = !trial[XLEN];
    rem_next    = q_bit ? trial[XLEN-1:0] : {rem_reg[XLEN-2:0], dvd_reg[XLEN-1]};
    dvd_next    = {dvd_reg[XLEN-2:0], q_bit};
    q_fix       = neg_q_reg ? -dvd_next : dvd_next;
    r_fix       = neg_r_reg ? -rem_next : rem_next;
    raw         = is_rem_reg ? r_fix : q_fix;
    calc_result = is_w_reg ? sext32(raw[HALF-1:0]) : raw;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= DIV_IDLE;
      cnt_reg     <= '0;
      dvd_reg     <= '0;
      rem_reg     <= '0;
      div_reg     <= '0;
      is_w_reg    <= 1'b0;
      is_rem_reg  <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      out_valid_o <= 1'b0;
      result_o    <= '0;
      tag_o       <= '0;
    end else if (flush_i) begin
      state_reg   <= DIV_IDLE;
      out_valid_o <= 1'b0;
    end else begin
      case (state_reg)
        DIV_IDLE: begin
          if (in_valid_i) begin
            tag_o      <= tag_i;
            is_w_reg   <= dec.is_w;
            is_rem_reg <= dec.is_rem;
            neg_q_reg  <= a_neg ^ b_neg;
            neg_r_reg  <= a_neg;
            rem_reg    <= '0;
            div_reg    <= b_mag;
            // W dividends are pre-shifted so 32 iterations consume all significant bits.
            dvd_reg    <= dec.is_w ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
            cnt_reg    <= dec.is_w ? 7'(DIV_ITER_32) : 7'(DIV_ITER_64);
            if (special) begin
              result_o    <= special_result;
              out_valid_o <= 1'b1;
              state_reg   <= DIV_DONE;
            end else begin
              state_reg <= DIV_CALC;
            end
          end
        end
        DIV_CALC: begin
          cnt_reg <= cnt_reg - 7'd1;
          rem_reg <= rem_next;
          dvd_reg <= dvd_next;
          if (cnt_reg == 7'd1) begin
            result_o    <= calc_result;
            out_valid_o <= 1'b1;
            state_reg   <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state_reg   <= DIV_IDLE;
          end
        end
        default: state_reg <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv64_div_unit.sv
// Self-checking bench for rv64_div_unit: directed vectors, flush/reset, random ops vs. arithmetic model.
module tb_rv64_div_unit;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  op_i;
  logic [63:0] rs1_i;
  logic [63:0] rs2_i;
  logic [4:0]  tag_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] result_o;
  logic [4:0]  tag_o;
  logic        busy_o;

  int vectors;
  int miscompares;

  rv64_div_unit #(.TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .result_o(result_o), .tag_o(tag_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RISC-V M-extension divide semantics written with plain integer arithmetic.
  function automatic logic [63:0] ref_div(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    longint      sa, sb;
    int          sa32, sb32;
    logic [31:0] r32;
    logic [63:0] r;
    sa = a; sb = b; sa32 = a[31:0]; sb32 = b[31:0];
    r = '0; r32 = '0;
    case (op)
      4'd4: if (b == 0) r = '1; else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = a; else r = 64'(sa / sb);
      4'd5: if (b == 0) r = '1; else r = a / b;
      4'd6: if (b == 0) r = a; else if (a == 64'h8000_0000_0000_0000 && sb == -1) r = 0; else r = 64'(sa % sb);
      4'd7: if (b == 0) r = a; else r = a % b;
      4'd9: if (b[31:0] == 0) r32 = '1; else if (a[31:0] == 32'h8000_0000 && sb32 == -1) r32 = 32'h8000_0000; else r32 = 32'(sa32 / sb32);
      4'd10: if (b[31:0] == 0) r32 = '1; else r32 = a[31:0] / b[31:0];
      4'd11: if (b[31:0] == 0) r32 = a[31:0]; else if (a[31:0] == 32'h8000_0000 && sb32 == -1) r32 = 0; else r32 = 32'(sa32 % sb32);
      4'd12: if (b[31:0] == 0) r32 = a[31:0]; else r32 = a[31:0] % b[31:0];
      default: r = '0;
    endcase
    if (op >= 4'd9 && op <= 4'd12) r = {{32{r32[31]}}, r32};
    return r;
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    bit w, s;
    if (!(op inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12})) return 1;
    w = (op >= 4'd9);
    s = op inside {4'd4, 4'd6, 4'd9, 4'd11};
    if (w && b[31:0] == 0) return 1;
    if (!w && b == 0) return 1;
    if (s && !w && a == 64'h8000_0000_0000_0000 && b == '1) return 1;
    if (s && w && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
    return w ? 33 : 65;
  endfunction

  // Issue one op, wait for its result (lat counts the accept edge as 1), then consume it.
  task automatic do_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tg, output logic [63:0] res, output logic [4:0] rtag,
                       output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready_o && guard < 200) begin @(negedge clk); guard++; end
    op_i = op; rs1_i = a; rs2_i = b; tag_i = tg; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 200) begin @(posedge clk); #1; lat++; end
    if (!out_valid_o) lat = -1;
    res = result_o; rtag = tag_o;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid_o, result_o, tag_o, busy_o, in_ready_o} !== 72'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b result=%h tag=%0d busy=%b ready=%b, expected all 0",
               out_valid_o, result_o, tag_o, busy_o, in_ready_o);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got in_ready=%b, expected 1", in_ready_o);
    end
  endtask

  task automatic test_directed();
    logic [3:0]  d_op  [10] = '{4'd5, 4'd7, 4'd4, 4'd6, 4'd4, 4'd6, 4'd4, 4'd9, 4'd11, 4'd0};
    logic [63:0] d_a   [10] = '{64'd100, 64'd100, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FF9C,
                                64'd42, 64'd42, 64'h8000_0000_0000_0000, 64'h0000_0000_8000_0000,
                                64'h0000_0000_8000_0000, 64'd55};
    logic [63:0] d_b   [10] = '{64'd7, 64'd7, 64'd7, 64'd7, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                                64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'd5};
    logic [63:0] d_exp [10] = '{64'd14, 64'd2, 64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'd42, 64'h8000_0000_0000_0000,
                                64'hFFFF_FFFF_8000_0000, 64'd0, 64'd0};
    int          d_lat [10] = '{65, 65, 65, 65, 1, 1, 1, 1, 1, 1};
    logic [63:0] res;
    logic [4:0]  rt;
    int          lat;
    for (int i = 0; i < 10; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], 5'(i + 3), res, rt, lat);
      vectors++;
      if (res !== d_exp[i]) begin
        miscompares++;
        $display("FAIL directed_result[%0d]: got %h, expected %h", i, res, d_exp[i]);
      end
      vectors++;
      if (lat !== d_lat[i]) begin
        miscompares++;
        $display("FAIL directed_latency[%0d]: got %0d, expected %0d", i, lat, d_lat[i]);
      end
      vectors++;
      if (rt !== 5'(i + 3)) begin
        miscompares++;
        $display("FAIL directed_tag[%0d]: got %0d, expected %0d", i, rt, i + 3);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    @(negedge clk);
    op_i = 4'd10; rs1_i = 64'hDEAD_0000_FFFF_FFFE; rs2_i = 64'd2; tag_i = 5'd21; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    lat = 1;
    while (!out_valid_o && lat < 200) begin @(posedge clk); #1; lat++; end
    vectors++;
    if (lat !== 33) begin
      miscompares++;
      $display("FAIL divuw_latency: got %0d, expected 33", lat);
    end
    @(negedge clk);
    in_valid_i = 1'b1; op_i = 4'd5; tag_i = 5'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({out_valid_o, in_ready_o, result_o, tag_o} !== {1'b1, 1'b0, 64'h0000_0000_7FFF_FFFF, 5'd21}) begin
        miscompares++;
        $display("FAIL divuw_hold[%0d]: got valid=%b ready=%b result=%h tag=%0d, expected 1 0 00000000_7fffffff 21",
                 i, out_valid_o, in_ready_o, result_o, tag_o);
      end
    end
    @(negedge clk);
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk); #1;
    out_ready_i = 1'b0;
    vectors++;
    if ({out_valid_o, busy_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL divuw_consume: got valid=%b busy=%b, expected 0 0", out_valid_o, busy_o);
    end
  endtask

  task automatic test_flush();
    logic [63:0] res;
    logic [4:0]  rt;
    int          lat;
    bit          seen;
    @(negedge clk);
    op_i = 4'd5; rs1_i = 64'hFFFF_0000_1234_5678; rs2_i = 64'd3; tag_i = 5'd3; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy_o, out_valid_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_calc: got busy=%b valid=%b, expected 0 0", busy_o, out_valid_o);
    end
    // Keep flush high in IDLE with a pending request: it must not be accepted.
    @(negedge clk);
    in_valid_i = 1'b1;
    vectors++;
    if (in_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_ready: got in_ready=%b, expected 0", in_ready_o);
    end
    @(posedge clk); #1;
    @(negedge clk);
    flush_i = 1'b0; in_valid_i = 1'b0;
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (out_valid_o || busy_o) seen = 1'b1; end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_drop: got activity=%b after flush, expected 0", seen);
    end
    do_op(4'd5, 64'd9, 64'd3, 5'd17, res, rt, lat);
    vectors++;
    if ({res, rt} !== {64'd3, 5'd17} || lat !== 65) begin
      miscompares++;
      $display("FAIL flush_next_op: got result=%h tag=%0d lat=%0d, expected 3 17 65", res, rt, lat);
    end
    // Flush while a result waits in DONE, with out_ready also high.
    @(negedge clk);
    op_i = 4'd4; rs1_i = 64'd42; rs2_i = 64'd0; tag_i = 5'd9; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    vectors++;
    if (out_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_done_setup: got valid=%b, expected 1", out_valid_o);
    end
    @(negedge clk);
    flush_i = 1'b1; out_ready_i = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({out_valid_o, busy_o} !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_done: got valid=%b busy=%b, expected 0 0", out_valid_o, busy_o);
    end
    @(negedge clk);
    flush_i = 1'b0; out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    logic [4:0]  rt;
    int          lat;
    @(negedge clk);
    op_i = 4'd5; rs1_i = 64'h0123_4567_89AB_CDEF; rs2_i = 64'd11; tag_i = 5'd22; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({out_valid_o, result_o, tag_o, busy_o, in_ready_o} !== 72'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got valid=%b result=%h tag=%0d busy=%b ready=%b, expected all 0",
               out_valid_o, result_o, tag_o, busy_o, in_ready_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(4'd4, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd30, res, rt, lat);
    vectors++;
    if ({res, rt} !== {64'hFFFF_FFFF_FFFF_FFF2, 5'd30}) begin
      miscompares++;
      $display("FAIL reset_recover: got result=%h tag=%0d, expected fffffffffffffff2 30", res, rt);
    end
  endtask

  task automatic test_random();
    logic [3:0]  legal_ops [8] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12};
    logic [3:0]  op;
    logic [63:0] a, b, res, exp_res;
    logic [4:0]  tg, rt;
    int          lat, elat, mode;
    bit          w;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 15) == 0) ? 4'(($urandom_range(0, 1) == 0) ? 1 : 14) : legal_ops[$urandom_range(0, 7)];
      w  = (op >= 4'd9 && op <= 4'd12);
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      mode = $urandom_range(0, 7);
      case (mode)
        0: b = w ? {$urandom, 32'h0} : 64'd0;
        1: b = 64'($urandom_range(1, 20));
        2: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        3: b = {32'h0, $urandom};
        4: b = -64'($urandom_range(1, 1000));
        default: ;
      endcase
      tg = 5'($urandom);
      exp_res = ref_div(op, a, b);
      elat = exp_lat(op, a, b);
      do_op(op, a, b, tg, res, rt, lat);
      vectors++;
      if (res !== exp_res || rt !== tg || lat !== elat) begin
        miscompares++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got result=%h tag=%0d lat=%0d, expected %h %0d %0d",
                 i, op, a, b, res, rt, lat, exp_res, tg, elat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc_edges[$];
    int e;
    bit will_acc;
    int guard;
    e = 0;
    @(negedge clk);
    op_i = 4'd5; rs1_i = 64'd1000; rs2_i = 64'd10; tag_i = 5'd5;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    while (acc_edges.size() < 3 && e < 400) begin
      will_acc = in_ready_o && in_valid_i;
      @(posedge clk);
      e++;
      if (will_acc) acc_edges.push_back(e);
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    guard = 0;
    while (busy_o && guard < 200) begin @(negedge clk); guard++; end
    out_ready_i = 1'b0;
    vectors++;
    if (acc_edges.size() !== 3) begin
      miscompares++;
      $display("FAIL b2b_accepts: got %0d accepts, expected 3", acc_edges.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        vectors++;
        if (acc_edges[i] - acc_edges[i-1] !== 66) begin
          miscompares++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles, expected 66", i, acc_edges[i] - acc_edges[i-1]);
        end
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    op_i = '0; rs1_i = '0; rs2_i = '0; tag_i = '0;
    test_reset();
    test_directed();
    test_hold();
    test_flush();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
